// File: rtl/cnn_pkg.sv
// Shared types for the CNN datapath: Q4.12 samples, 64-lane vectors, packer fill states.
package cnn_pkg;

    localparam int unsigned VEC_LANES = 64;
    localparam int unsigned Q_W       = 16;
    localparam int unsigned IDX_W     = $clog2(VEC_LANES);

    typedef logic signed [Q_W-1:0] q4_12_t;
    typedef q4_12_t vec64_t [0:VEC_LANES-1];

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/stream_vec_packer.sv
// Packs a scalar Q4.12 sample stream into 64-lane vectors with a fill buffer
// ping-ponged against a registered vector output.
module stream_vec_packer
    import cnn_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   s_valid,
    input  q4_12_t s_data,
    input  logic   s_last,
    output logic   s_ready,
    output vec64_t output_data,
    output logic   vec_last,
    output logic   valid_out,
    input  logic   ready_in
);

    fill_state_t      state;
    fill_state_t      state_nxt;
    logic [IDX_W-1:0] idx;
    vec64_t           fill_buf;
    vec64_t           done_vec;
    logic             held_last;

    logic accept;
    logic complete;
    logic handshake;
    logic out_free;
    logic direct_xfer;
    logic held_xfer;

    assign s_ready     = (state == FILL);
    assign accept      = s_valid && s_ready;
    assign complete    = accept && ((idx == IDX_W'(VEC_LANES - 1)) || s_last);
    assign handshake   = valid_out && ready_in;
    assign out_free    = !valid_out || ready_in;
    assign direct_xfer = complete && out_free;
    assign held_xfer   = (state == FULL) && handshake;

    // Completed vector: lanes already filled, the closing sample, zeros above it
    always_comb begin
        for (int i = 0; i < VEC_LANES; i++) begin
            if (IDX_W'(i) < idx) begin
                done_vec[i] = fill_buf[i];
            end else if (IDX_W'(i) == idx) begin
                done_vec[i] = s_data;
            end else begin
                done_vec[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (complete && !out_free) state_nxt = FULL;
            FULL:    if (handshake) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Fill side: lane counter and the buffer that holds a vector blocked by the output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            held_last <= 1'b0;
            for (int i = 0; i < VEC_LANES; i++) begin
                fill_buf[i] <= '0;
            end
        end else if (accept) begin
            if (complete) begin
                idx <= '0;
                if (!out_free) begin
                    fill_buf  <= done_vec;
                    held_last <= s_last;
                end
            end else begin
                fill_buf[idx] <= s_data;
                idx           <= idx + IDX_W'(1);
            end
        end
    end

    // Output register: loads on transfer, drops valid only on a handshake with nothing behind it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            vec_last  <= 1'b0;
            for (int i = 0; i < VEC_LANES; i++) begin
                output_data[i] <= '0;
            end
        end else if (direct_xfer) begin
            output_data <= done_vec;
            vec_last    <= s_last;
            valid_out   <= 1'b1;
        end else if (held_xfer) begin
            output_data <= fill_buf;
            vec_last    <= held_last;
            valid_out   <= 1'b1;
        end else if (handshake) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_vec_packer.sv
// Directed bench for stream_vec_packer with hand-computed expected vectors.
module tb_stream_vec_packer;
    import cnn_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   s_valid;
    q4_12_t s_data;
    logic   s_last;
    logic   s_ready;
    vec64_t output_data;
    logic   vec_last;
    logic   valid_out;
    logic   ready_in;

    int errors = 0;
    int checks = 0;

    stream_vec_packer dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .output_data (output_data),
        .vec_last    (vec_last),
        .valid_out   (valid_out),
        .ready_in    (ready_in)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stream inputs, then sample #1 after the edge
    task automatic cyc(input logic v, input logic [15:0] d, input logic l);
        s_valid = v;
        s_data  = q4_12_t'(d);
        s_last  = l;
        @(posedge clk);
        #1;
    endtask

    int drops;
    int early;
    int unstable;
    logic [15:0] exp_lane;

    initial begin
        reset    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 16'(valid_out), 16'h0);
        check_eq("rst_last", 16'(vec_last), 16'h0);
        check_eq("rst_lane0", output_data[0], 16'h0);
        check_eq("rst_lane63", output_data[63], 16'h0);
        reset = 1'b1;
        #1;
        check_eq("rst_s_ready", 16'(s_ready), 16'h1);

        // Full vector, no s_last
        ready_in = 1'b1;
        drops = 0;
        early = 0;
        for (int k = 0; k < 64; k++) begin
            if (!s_ready) drops++;
            cyc(1'b1, 16'(k * 16'h0040), 1'b0);
            if (k < 63 && valid_out) early++;
        end
        check_eq("full_drops", 16'(drops), 16'h0);
        check_eq("full_early", 16'(early), 16'h0);
        check_eq("full_valid", 16'(valid_out), 16'h1);
        check_eq("full_last", 16'(vec_last), 16'h0);
        for (int k = 0; k < 64; k++) begin
            check_eq($sformatf("full_lane%0d", k), output_data[k], 16'(k * 16'h0040));
        end
        cyc(1'b0, 16'h0, 1'b0);
        check_eq("full_pulse_end", 16'(valid_out), 16'h0);

        // Short vector closed by s_last on the 10th sample
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 16'hF000, k == 9);
        end
        check_eq("short_valid", 16'(valid_out), 16'h1);
        check_eq("short_last", 16'(vec_last), 16'h1);
        for (int k = 0; k < 64; k++) begin
            exp_lane = (k < 10) ? 16'hF000 : 16'h0000;
            check_eq($sformatf("short_lane%0d", k), output_data[k], exp_lane);
        end
        cyc(1'b1, 16'h1234, 1'b1);
        check_eq("restart_valid", 16'(valid_out), 16'h1);
        check_eq("restart_lane0", output_data[0], 16'h1234);
        check_eq("restart_lane1", output_data[1], 16'h0000);
        check_eq("restart_last", 16'(vec_last), 16'h1);
        cyc(1'b0, 16'h0, 1'b0);
        check_eq("restart_end", 16'(valid_out), 16'h0);

        // Back-pressure: 128 samples with the consumer stalled
        ready_in = 1'b0;
        drops = 0;
        unstable = 0;
        for (int k = 0; k < 128; k++) begin
            if (!s_ready) drops++;
            cyc(1'b1, 16'(k), 1'b0);
            if (k >= 63 && (!valid_out || output_data[5] !== 16'd5 || output_data[63] !== 16'd63))
                unstable++;
        end
        check_eq("bp_drops", 16'(drops), 16'h0);
        check_eq("bp_unstable", 16'(unstable), 16'h0);
        check_eq("bp_s_ready_low", 16'(s_ready), 16'h0);
        cyc(1'b1, 16'hDEAD, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        check_eq("bp_hold_ready", 16'(s_ready), 16'h0);
        check_eq("bp_hold_lane0", output_data[0], 16'h0000);
        check_eq("bp_hold_lane63", output_data[63], 16'd63);
        ready_in = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);
        ready_in = 1'b0;
        check_eq("bp_second_valid", 16'(valid_out), 16'h1);
        check_eq("bp_second_lane0", output_data[0], 16'd64);
        check_eq("bp_second_lane63", output_data[63], 16'd127);
        check_eq("bp_second_last", 16'(vec_last), 16'h0);
        check_eq("bp_s_ready_back", 16'(s_ready), 16'h1);
        ready_in = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);
        check_eq("bp_drain", 16'(valid_out), 16'h0);

        // Completion on the same edge as the output handshake
        ready_in = 1'b0;
        cyc(1'b1, 16'h0111, 1'b0);
        cyc(1'b1, 16'h0111, 1'b0);
        cyc(1'b1, 16'h0111, 1'b1);
        check_eq("sim_a_valid", 16'(valid_out), 16'h1);
        check_eq("sim_a_lane2", output_data[2], 16'h0111);
        cyc(1'b1, 16'h0222, 1'b0);
        check_eq("sim_a_held", output_data[0], 16'h0111);
        ready_in = 1'b1;
        cyc(1'b1, 16'h0333, 1'b1);
        check_eq("sim_valid", 16'(valid_out), 16'h1);
        check_eq("sim_lane0", output_data[0], 16'h0222);
        check_eq("sim_lane1", output_data[1], 16'h0333);
        check_eq("sim_lane2", output_data[2], 16'h0000);
        check_eq("sim_last", 16'(vec_last), 16'h1);
        check_eq("sim_state_fill", 16'(s_ready), 16'h1);
        cyc(1'b0, 16'h0, 1'b0);
        check_eq("sim_drain", 16'(valid_out), 16'h0);

        // Gaps: garbage on unqualified cycles must not land in the vector
        for (int k = 0; k < 39; k++) begin
            if (k % 2 == 0)
                cyc(1'b1, 16'(16'h0100 + k / 2), k == 38);
            else
                cyc(1'b0, 16'($urandom), 1'($urandom));
        end
        check_eq("gap_valid", 16'(valid_out), 16'h1);
        check_eq("gap_last", 16'(vec_last), 16'h1);
        for (int k = 0; k < 64; k++) begin
            exp_lane = (k < 20) ? 16'(16'h0100 + k) : 16'h0000;
            check_eq($sformatf("gap_lane%0d", k), output_data[k], exp_lane);
        end
        cyc(1'b0, 16'h0, 1'b0);

        // Reset mid-fill with a vector parked in the output register
        ready_in = 1'b0;
        cyc(1'b1, 16'h7777, 1'b1);
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1, 16'h5555, 1'b0);
        end
        check_eq("prerst_valid", 16'(valid_out), 16'h1);
        reset = 1'b0;
        #2;
        check_eq("midrst_valid", 16'(valid_out), 16'h0);
        check_eq("midrst_lane0", output_data[0], 16'h0000);
        check_eq("midrst_last", 16'(vec_last), 16'h0);
        #2;
        reset = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        early = 0;
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, 16'h1000, 1'b0);
            if (k < 63 && valid_out) early++;
        end
        check_eq("postrst_early", 16'(early), 16'h0);
        check_eq("postrst_valid", 16'(valid_out), 16'h1);
        check_eq("postrst_last", 16'(vec_last), 16'h0);
        for (int k = 0; k < 64; k++) begin
            check_eq($sformatf("postrst_lane%0d", k), output_data[k], 16'h1000);
        end
        cyc(1'b0, 16'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
